// File: rtl/pc_fetch_controller.sv
// Instruction fetch sequencer: requests a word from instruction memory,
// latches it, waits for the datapath to execute it, then strobes the PC.
// A memory response that never arrives parks the block in a sticky FAULT
// state that only reset clears.
//
//   state  | meaning
//   IDLE   | parked, waiting for start
//   REQ    | imem_req high, waiting for imem_gnt
//   WAIT   | granted, counting cycles until imem_rvalid or timeout
//   EXEC   | instr latched and stable, waiting for exec_done
//   UPDATE | one-cycle pc_load strobe, retire count bumped
//   FAULT  | memory timed out, frozen until reset
module pc_fetch_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        exec_done,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic [2:0]  func,
    output logic        pc_load,
    output logic [31:0] instr_count,
    output logic        fault,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Last WAIT count value; reaching it without rvalid means timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [31:0] count_q;
    logic        timeout_hit;

    assign timeout_hit = (wait_cnt == WAIT_LAST);

    // Next-state decode; inputs outside their owning state are ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_REQ;
            ST_REQ:    if (imem_gnt) state_next = ST_WAIT;
            ST_WAIT: begin
                // rvalid takes priority over a same-cycle timeout
                if (imem_rvalid)      state_next = ST_EXEC;
                else if (timeout_hit) state_next = ST_FAULT;
            end
            ST_EXEC:   if (exec_done) state_next = ST_UPDATE;
            ST_UPDATE: state_next = halt ? ST_IDLE : ST_REQ;
            ST_FAULT:  state_next = ST_FAULT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Wait counter: zero outside WAIT, so it is clear on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wait_cnt <= 8'd0;
        else if (state == ST_WAIT) wait_cnt <= wait_cnt + 8'd1;
        else                       wait_cnt <= 8'd0;
    end

    // Instruction register; valid from the latch until UPDATE retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else if (state == ST_WAIT && imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (state == ST_UPDATE) begin
            instr_valid <= 1'b0;
        end
    end

    // Registered strobes: pc_load is a clean flop output for the whole
    // UPDATE cycle, so the PC can capture it on the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_load <= 1'b0;
            count_q <= 32'd0;
            fault   <= 1'b0;
        end else begin
            pc_load <= (state_next == ST_UPDATE);
            if (state == ST_EXEC && state_next == ST_UPDATE)
                count_q <= count_q + 32'd1;
            if (state_next == ST_FAULT)
                fault <= 1'b1;
        end
    end

    assign instr_count = count_q;
    assign imem_req    = (state == ST_REQ);
    assign busy        = (state != ST_IDLE);
    assign opcode      = instr[6:0];
    assign func        = instr[14:12];

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Randomized bench for pc_fetch_controller. Each instruction is described
// by its grant delay, response delay and execute delay; expected timing and
// outputs follow directly from those delays.
module tb_pc_fetch_controller;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        exec_done = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [2:0]  func;
    logic        pc_load;
    logic [31:0] instr_count;
    logic        fault;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_count = 32'd0;

    pc_fetch_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .exec_done   (exec_done),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .func        (func),
        .pc_load     (pc_load),
        .instr_count (instr_count),
        .fault       (fault),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Randomize every input that the current state should ignore.
    task automatic noise();
        imem_gnt    = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
        exec_done   = 1'($urandom_range(0, 1));
        halt        = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
    endtask

    task automatic do_reset();
        start = 0; halt = 0; exec_done = 0; imem_gnt = 0; imem_rvalid = 0;
        rst_n = 1'b0;
        exp_count = 32'd0;
        #3;
        chk("rst_instr", instr, 32'd0);
        chk("rst_ivalid", 32'(instr_valid), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_pcload", 32'(pc_load), 0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            start = 1'b0;
            tick();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_req", 32'(imem_req), 0);
        end
    endtask

    task automatic start_fetch();
        noise();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_req", 32'(imem_req), 1);
    endtask

    // Entry: the request cycle is visible. Exit: one cycle after UPDATE.
    task automatic run_instr(input int g, input int r, input int e,
                             input logic [31:0] data, input bit hlt);
        logic [6:0] exp_op;
        logic [2:0] exp_fn;
        exp_op = data[6:0];
        exp_fn = data[14:12];
        for (int i = 0; i <= g; i++) begin
            noise();
            imem_gnt = (i == g);
            chk("req_hold", 32'(imem_req), 1);
            chk("req_nopc", 32'(pc_load), 0);
            tick();
        end
        for (int i = 0; i <= r; i++) begin
            noise();
            imem_rvalid = (i == r);
            if (i == r) imem_rdata = data;
            chk("req_drop", 32'(imem_req), 0);
            chk("wait_busy", 32'(busy), 1);
            chk("wait_nofault", 32'(fault), 0);
            tick();
        end
        for (int i = 0; i <= e; i++) begin
            noise();
            exec_done = (i == e);
            chk("exec_instr", instr, data);
            chk("exec_ivalid", 32'(instr_valid), 1);
            chk("exec_opcode", 32'(opcode), 32'(exp_op));
            chk("exec_func", 32'(func), 32'(exp_fn));
            chk("exec_nopc", 32'(pc_load), 0);
            chk("exec_nofault", 32'(fault), 0);
            tick();
        end
        noise();
        halt = hlt;
        chk("upd_pcload", 32'(pc_load), 1);
        chk("upd_instr", instr, data);
        chk("upd_req", 32'(imem_req), 0);
        tick();
        exp_count = exp_count + 32'd1;
        noise();
        halt = 1'b0;
        chk("post_pcload", 32'(pc_load), 0);
        chk("post_ivalid", 32'(instr_valid), 0);
        chk("post_count", instr_count, exp_count);
        chk("post_busy", 32'(busy), hlt ? 0 : 1);
        chk("post_req", 32'(imem_req), hlt ? 0 : 1);
    endtask

    initial begin
        int c0;
        int g, r, e;
        bit hlt;
        bit in_req;

        #2;
        do_reset();
        idle_cycles(4);

        // Directed branch instruction, zero latency everywhere.
        start_fetch();
        run_instr(0, 0, 0, 32'h0000_0463, 1'b1);
        chk("dir_opcode", 32'(opcode), 32'h63);
        chk("dir_func", 32'(func), 0);
        chk("dir_count", instr_count, 32'd1);

        // Grant held off for three cycles.
        idle_cycles(2);
        start_fetch();
        run_instr(3, 0, 0, $urandom, 1'b1);

        // Response on the final allowed WAIT cycle.
        idle_cycles(1);
        start_fetch();
        run_instr(0, TIMEOUT - 1, 1, $urandom, 1'b1);
        chk("late_rvalid_nofault", 32'(fault), 0);

        // Random traffic.
        idle_cycles(1);
        start_fetch();
        in_req = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (!in_req) begin
                idle_cycles(int'($urandom_range(1, 3)));
                start_fetch();
            end
            g   = int'($urandom_range(0, 4));
            r   = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
            e   = int'($urandom_range(0, 3));
            hlt = ($urandom_range(0, 3) == 0);
            run_instr(g, r, e, $urandom, hlt);
            in_req = !hlt;
        end
        if (in_req) run_instr(0, 0, 0, $urandom, 1'b1);

        // Back-to-back minimum latency: four cycles per instruction.
        idle_cycles(1);
        start_fetch();
        c0 = cyc;
        for (int k = 0; k < 5; k++) run_instr(0, 0, 0, $urandom, k == 4);
        chk("throughput", 32'(cyc - c0), 32'd20);

        // Retire counter wrap.
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        exp_count = 32'hFFFF_FFFF;
        chk("preload", instr_count, 32'hFFFF_FFFF);
        start_fetch();
        run_instr(1, 1, 0, $urandom, 1'b1);
        chk("wrap_zero", instr_count, 32'd0);

        // Reset asserted while executing.
        idle_cycles(1);
        start_fetch();
        noise(); imem_gnt = 1'b1; tick();
        noise(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
        noise(); exec_done = 1'b0;
        chk("pre_rst_ivalid", 32'(instr_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 32'd0;
        chk("arst_instr", instr, 32'd0);
        chk("arst_ivalid", 32'(instr_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pcload", 32'(pc_load), 0);
        chk("arst_count", instr_count, 32'd0);
        chk("arst_req", 32'(imem_req), 0);
        exec_done = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'b0; imem_rvalid = 1'b1; imem_gnt = 1'b1; exec_done = 1'b1;
            imem_rdata = 32'h1234_5678;
            tick();
            chk("stale_busy", 32'(busy), 0);
            chk("stale_ivalid", 32'(instr_valid), 0);
            chk("stale_instr", instr, 32'd0);
            chk("stale_pcload", 32'(pc_load), 0);
        end

        // Memory timeout into sticky FAULT.
        start_fetch();
        noise(); imem_gnt = 1'b1; tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            noise();
            imem_rvalid = 1'b0;
            chk("to_nofault", 32'(fault), 0);
            chk("to_busy", 32'(busy), 1);
            tick();
        end
        chk("to_fault", 32'(fault), 1);
        chk("to_req", 32'(imem_req), 0);
        chk("to_pcload", 32'(pc_load), 0);
        for (int i = 0; i < 6; i++) begin
            noise();
            start = 1'b1; imem_rvalid = 1'b1; imem_gnt = 1'b1; exec_done = 1'b1;
            tick();
            chk("fault_sticky", 32'(fault), 1);
            chk("fault_busy", 32'(busy), 1);
            chk("fault_req", 32'(imem_req), 0);
            chk("fault_pcload", 32'(pc_load), 0);
            chk("fault_ivalid", 32'(instr_valid), 0);
            chk("fault_count", instr_count, exp_count);
        end
        start = 1'b0;
        do_reset();
        chk("post_rst_fault", 32'(fault), 0);
        chk("post_rst_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles allowed for an instruction-memory response; legal range 2..255.
REQ-002 CLK  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin fetching from IDLE.
REQ-005 halt  input  1  stop after the current instruction; sampled only in UPDATE.
REQ-006 exec_done  input  1  datapath has finished executing the current instruction.
REQ-007 imem_gnt  input  1  instruction memory accepted the request.
REQ-008 imem_rvalid  input  1  instruction memory read data valid.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 instr  output  32  latched instruction register.
REQ-012 instr_valid  output  1  instr holds a live instruction.
REQ-013 opcode  output  7  instr[6:0], driven to the PC branch-select logic.
REQ-014 func  output  3  instr[14:12], driven to the PC branch-select logic.
REQ-015 pc_load  output  1  one-cycle LOAD strobe to the PC register.
REQ-016 instr_count  output  32  count of retired instructions.
REQ-017 fault  output  1  sticky memory-timeout flag.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have six states: IDLE, REQ, WAIT, EXEC, UPDATE and FAULT.
REQ-020 IDLE: start=1 SHALL move to REQ; all other inputs are ignored.
REQ-021 REQ: imem_req SHALL be 1, decoded from state only; it SHALL hold until imem_gnt=1, which moves to WAIT.
REQ-022 WAIT: the wait counter SHALL clear on entry and increment each cycle.
REQ-023 WAIT: imem_rvalid=1 SHALL latch imem_rdata into instr, set instr_valid=1, and move to EXEC.
REQ-024 WAIT: if the counter reaches TIMEOUT-1 with imem_rvalid=0, the FSM SHALL move to FAULT.
REQ-025 WAIT: if imem_rvalid=1 in the same cycle the timeout is reached, rvalid SHALL win and the FSM goes to EXEC.
REQ-026 imem_rvalid or imem_gnt outside its owning state SHALL be ignored: no latch and no state change.
REQ-027 EXEC: the FSM SHALL hold until exec_done=1, then move to UPDATE; instr is stable throughout.
REQ-028 UPDATE: pc_load SHALL be 1 for exactly this one cycle, registered, so it is stable across the PC's falling-edge capture.
REQ-029 UPDATE: instr_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-030 UPDATE: instr_valid SHALL clear; the FSM then moves to IDLE if halt=1, else to REQ.
REQ-031 FAULT: fault=1, imem_req=0 and pc_load=0; the state SHALL be exited only by reset, and start is ignored.
REQ-032 Minimum throughput SHALL be 4 cycles per instruction (REQ, WAIT, EXEC, UPDATE) when gnt is immediate, rvalid arrives the cycle after gnt, and exec_done is already high.
REQ-033 opcode and func SHALL be combinational slices of instr; they are meaningful only while instr_valid=1.

Reset
REQ-034 RST=0 SHALL immediately force state IDLE and zero every output and internal counter: instr, instr_valid, imem_req, pc_load, instr_count, fault, busy, and the wait counter.
REQ-035 Reset asserted mid-operation (any state) SHALL abort the instruction with no pc_load pulse; a memory response arriving after release SHALL be ignored.
REQ-036 After RST rises, the first state change SHALL require start=1.

Verification
REQ-037 Reset, then start=1 for one cycle, gnt=1 immediately, rvalid next cycle with rdata=0x00000463, exec_done=1 -> pc_load pulses exactly one cycle, 4 cycles after start was sampled; opcode=0x63, func=0; instr_count=1.
REQ-038 gnt held low for 3 cycles -> imem_req stays 1 for all 4 REQ cycles and drops the cycle after gnt.
REQ-039 TIMEOUT=16, no rvalid -> FAULT after 16 WAIT cycles, fault=1 sticky; a later start=1 and rvalid=1 produce no change until reset.
REQ-040 rvalid on the final WAIT cycle -> EXEC, fault stays 0.
REQ-041 Run continuously with halt=0 -> back-to-back fetches; halt=1 during UPDATE -> IDLE, busy=0; instr_count preloaded to 0xFFFFFFFF wraps to 0.
REQ-042 RST pulsed low during EXEC -> all outputs 0 asynchronously, no pc_load; a stale rvalid after release is ignored.
